// File: rtl/lbm_step_ctrl.sv
// D2Q9 lattice-Boltzmann step controller: lattice init, one-cell-per-clock collide pass, streamer handoff.
// Define LBM_BOUNCEBACK_EN to write reversed pre-collision populations for cells inside the obstacle rectangle.
module lbm_step_ctrl #(
  parameter int LAT_W    = 205,
  parameter int LAT_H    = 154,
  parameter int DW       = 8,
  parameter int RD_LAT   = 2,
  parameter int COLL_LAT = 4,
  parameter int OBS_X0   = 40,
  parameter int OBS_Y0   = 60,
  parameter int OBS_W    = 4,
  parameter int OBS_H    = 34,
  localparam int N       = LAT_W * LAT_H,
  localparam int ADDR_W  = $clog2(N)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [1:0]        sw_in,
  input  logic              step_in,
  input  logic              run_in,
  input  logic              init_in,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [9*DW-1:0]   rd_data_in,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [9*DW-1:0]   wr_data_out,
  output logic              wr_en_out,
  output logic [9*DW-1:0]   coll_data_out,
  output logic              coll_valid_out,
  input  logic [9*DW-1:0]   coll_data_in,
  input  logic              coll_valid_in,
  output logic              stream_start_out,
  input  logic              stream_done_in,
  output logic              busy_out,
  output logic              step_done_out,
  output logic [31:0]       step_count_out,
  output logic [1:0]        dbg_state_out
);

  // Handshake: coll_valid_out/coll_valid_in and the stream start/done pulses are valid-only;
  // neither the collider nor the streamer can backpressure, so every asserted valid is consumed that cycle.
  typedef enum logic [1:0] {S_SETUP = 2'd0, S_WAIT = 2'd1, S_COLLIDE = 2'd2, S_STREAM = 2'd3} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  state_t              r_state, w_next;
  logic                r_step_q, w_step_rise;
  logic [ADDR_W-1:0]   r_rd_cnt, r_wr_cnt;
  logic                r_rd_active;
  logic [RD_LAT-1:0]   r_vld_pipe;
  logic                r_set_en;
  logic [ADDR_W-1:0]   r_set_addr;
  logic [9*DW-1:0]     r_set_data;
  logic [1:0]          r_sw, w_sw;
  logic                r_busy, r_stream_start, r_step_done;
  logic [31:0]         r_step_count;
  logic                w_coll_wr, w_go;
  logic [9*DW-1:0]     w_wr_word;

  function automatic logic [9*DW-1:0] init_word(input logic [1:0] sel);
    logic [DW-1:0] half;
    half = {1'b0, {(DW-1){1'b1}}};
    init_word = '0;
    for (int d = 0; d < 9; d++) begin
      case (sel)
        2'b00:   init_word[d*DW +: DW] = DW'(10);
        2'b01:   init_word[d*DW +: DW] = '0;
        2'b10:   init_word[d*DW +: DW] = half;
        default: init_word[d*DW +: DW] = (d == 3) ? half : DW'(15);
      endcase
    end
  endfunction

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_SETUP;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_SETUP:   if (r_wr_cnt == LAST) w_next = S_WAIT;
      S_WAIT: begin
        if (init_in)                   w_next = S_SETUP;
        else if (w_step_rise || run_in) w_next = S_COLLIDE;
      end
      S_COLLIDE: if (w_coll_wr && (r_wr_cnt == LAST)) w_next = S_STREAM;
      S_STREAM:  if (stream_done_in) w_next = S_WAIT;
      default:   w_next = S_SETUP;
    endcase
  end

  // sw_in is taken live on the first SETUP cycle and held for the rest of the pass.
  always_comb begin
    w_step_rise = step_in && !r_step_q;
    w_coll_wr   = (r_state == S_COLLIDE) && coll_valid_in;
    w_go        = (r_state == S_WAIT) && (w_next == S_COLLIDE);
    w_sw        = (r_wr_cnt == '0) ? sw_in : r_sw;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_step_q       <= 1'b0;
      r_rd_cnt       <= '0;
      r_wr_cnt       <= '0;
      r_rd_active    <= 1'b0;
      r_vld_pipe     <= '0;
      r_set_en       <= 1'b0;
      r_set_addr     <= '0;
      r_set_data     <= '0;
      r_sw           <= '0;
      r_busy         <= 1'b0;
      r_stream_start <= 1'b0;
      r_step_done    <= 1'b0;
      r_step_count   <= '0;
    end else begin
      r_step_q       <= step_in;
      r_set_en       <= 1'b0;
      r_stream_start <= 1'b0;
      r_step_done    <= 1'b0;
      r_busy         <= (w_next != S_WAIT);
      r_vld_pipe[0]  <= r_rd_active;
      for (int i = 1; i < RD_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      case (r_state)
        S_SETUP: begin
          r_set_en   <= 1'b1;
          r_set_addr <= r_wr_cnt;
          r_set_data <= init_word(w_sw);
          if (r_wr_cnt == '0) r_sw <= sw_in;
          r_wr_cnt   <= (r_wr_cnt == LAST) ? '0 : r_wr_cnt + 1'b1;
        end
        S_WAIT: begin
          if (w_go) begin
            r_rd_active <= 1'b1;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
          end
        end
        S_COLLIDE: begin
          if (r_rd_active) begin
            if (r_rd_cnt == LAST) begin
              r_rd_active <= 1'b0;
              r_rd_cnt    <= '0;
            end else begin
              r_rd_cnt <= r_rd_cnt + 1'b1;
            end
          end
          if (w_coll_wr) r_wr_cnt <= (r_wr_cnt == LAST) ? '0 : r_wr_cnt + 1'b1;
          if (w_next == S_STREAM) r_stream_start <= 1'b1;
        end
        S_STREAM: begin
          if (stream_done_in) begin
            r_step_count <= r_step_count + 32'd1;
            r_step_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LBM_BOUNCEBACK_EN
  localparam int XW = (LAT_W > 1) ? $clog2(LAT_W) : 1;
  localparam int YW = (LAT_H > 1) ? $clog2(LAT_H) : 1;

  logic [9*DW-1:0] r_dly [COLL_LAT];
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic            w_obs;
  logic [9*DW-1:0] w_rev;

  // Pre-collision data travels beside the collider so it lines up with coll_valid_in.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < COLL_LAT; i++) r_dly[i] <= '0;
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_dly[0] <= coll_data_out;
      for (int i = 1; i < COLL_LAT; i++) r_dly[i] <= r_dly[i-1];
      if (w_go) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_coll_wr) begin
        if (r_x == XW'(LAT_W - 1)) begin
          r_x <= '0;
          r_y <= (r_y == YW'(LAT_H - 1)) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_rev = '0;
    for (int d = 0; d < 9; d++)
      w_rev[d*DW +: DW] = r_dly[COLL_LAT-1][((d == 0) ? 0 : ((d + 3) % 8) + 1)*DW +: DW];
    w_obs = (int'(r_x) >= OBS_X0) && (int'(r_x) < OBS_X0 + OBS_W) &&
            (int'(r_y) >= OBS_Y0) && (int'(r_y) < OBS_Y0 + OBS_H);
  end

  assign w_wr_word = w_obs ? w_rev : coll_data_in;
`else
  assign w_wr_word = coll_data_in;
`endif

  assign rd_addr_out      = r_rd_cnt;
  assign coll_valid_out   = r_vld_pipe[RD_LAT-1];
  assign coll_data_out    = coll_valid_out ? rd_data_in : '0;
  assign wr_en_out        = r_set_en | w_coll_wr;
  assign wr_addr_out      = r_set_en ? r_set_addr : (w_coll_wr ? r_wr_cnt : '0);
  assign wr_data_out      = r_set_en ? r_set_data : (w_coll_wr ? w_wr_word : '0);
  assign stream_start_out = r_stream_start;
  assign busy_out         = r_busy | r_set_en;
  assign step_done_out    = r_step_done;
  assign step_count_out   = r_step_count;
  assign dbg_state_out    = r_state;

endmodule

// File: tb/tb_lbm_step_ctrl.sv
// Bench for lbm_step_ctrl on a 4x3 lattice with a BRAM model, a fixed-latency collider model and a streamer model.
module tb_lbm_step_ctrl;
  localparam int LAT_W = 4, LAT_H = 3, N = 12, DW = 8, RD_LAT = 2, COLL_LAT = 4;
  localparam int ADDR_W = 4, WW = 9 * DW, EW = ADDR_W + WW;

  // clock / reset
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  logic [1:0]        sw_in;
  logic              step_in, run_in, init_in;
  logic [ADDR_W-1:0] rd_addr_out, wr_addr_out;
  logic [WW-1:0]     rd_data_in, wr_data_out, coll_data_out, coll_data_in;
  logic              wr_en_out, coll_valid_out, coll_valid_in;
  logic              stream_start_out, stream_done_in, busy_out, step_done_out;
  logic [31:0]       step_count_out;
  logic [1:0]        dbg_state_out;

  lbm_step_ctrl #(
    .LAT_W(LAT_W), .LAT_H(LAT_H), .DW(DW), .RD_LAT(RD_LAT), .COLL_LAT(COLL_LAT),
    .OBS_X0(1), .OBS_Y0(1), .OBS_W(1), .OBS_H(1)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .sw_in(sw_in), .step_in(step_in), .run_in(run_in),
    .init_in(init_in), .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .wr_en_out(wr_en_out),
    .coll_data_out(coll_data_out), .coll_valid_out(coll_valid_out),
    .coll_data_in(coll_data_in), .coll_valid_in(coll_valid_in),
    .stream_start_out(stream_start_out), .stream_done_in(stream_done_in),
    .busy_out(busy_out), .step_done_out(step_done_out), .step_count_out(step_count_out),
    .dbg_state_out(dbg_state_out)
  );

  // BRAM model, read latency 2
  logic [WW-1:0]     mem [N];
  logic [WW-1:0]     rd_p1 = '0, rd_p2 = '0;
  logic              poke_en = 1'b0;
  logic [ADDR_W-1:0] poke_addr = '0;
  logic [WW-1:0]     poke_data = '0;
  always @(posedge clk_in) begin
    rd_p1 <= mem[rd_addr_out];
    rd_p2 <= rd_p1;
    if (wr_en_out) mem[wr_addr_out] <= wr_data_out;
    if (poke_en) mem[poke_addr] <= poke_data;
  end
  assign rd_data_in = rd_p2;

  // collider model: adds coll_add to every lane, latency COLL_LAT
  logic [7:0]          coll_add = '0;
  logic [WW-1:0]       cp_d [COLL_LAT];
  logic [COLL_LAT-1:0] cp_v = '0;

  function automatic logic [WW-1:0] add_lanes(input logic [WW-1:0] w, input logic [7:0] k);
    add_lanes = w;
    for (int d = 0; d < 9; d++) add_lanes[d*8 +: 8] = w[d*8 +: 8] + k;
  endfunction

  always @(posedge clk_in) begin
    cp_v <= {cp_v[COLL_LAT-2:0], coll_valid_out};
    cp_d[0] <= add_lanes(coll_data_out, coll_add);
    for (int i = 1; i < COLL_LAT; i++) cp_d[i] <= cp_d[i-1];
  end
  assign coll_valid_in = cp_v[COLL_LAT-1];
  assign coll_data_in  = cp_d[COLL_LAT-1];

  // streamer model: auto reply 5 cycles after start, or manual pulse
  logic auto_done = 1'b0, r_auto = 1'b0, man_done = 1'b0;
  assign stream_done_in = r_auto | man_done;
  always begin
    @(negedge clk_in);
    if (auto_done && stream_start_out) begin
      repeat (5) @(negedge clk_in);
      r_auto = 1'b1;
      @(negedge clk_in);
      r_auto = 1'b0;
    end
  end

  // scoreboard
  int checks = 0, errors = 0;
  int n_start = 0, n_done = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_in) begin
    if (wr_en_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected actual addr=%0d data=%0h expected no write", wr_addr_out, wr_data_out);
      end else begin
        chk("wr", {wr_addr_out, wr_data_out}, exp_q.pop_front());
      end
    end
    if (stream_start_out) n_start++;
    if (step_done_out) n_done++;
  end

  // driver helpers
  function automatic logic [WW-1:0] mk_word(input logic [7:0] other, input logic [7:0] d3);
    mk_word = '0;
    for (int d = 0; d < 9; d++) mk_word[d*8 +: 8] = (d == 3) ? d3 : other;
  endfunction

  task automatic push_pass(input logic [WW-1:0] w, input int count);
    for (int k = 0; k < count; k++) exp_q.push_back({ADDR_W'(k), w});
  endtask

  function automatic logic sig_sel(input int which);
    case (which)
      0:       sig_sel = wr_en_out;
      1:       sig_sel = stream_start_out;
      default: sig_sel = step_done_out;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int budget, output int at);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!sig_sel(which) && n < budget);
    at = cyc;
    if (!sig_sel(which)) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=0 expected=1", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_out && n < 500) begin
      @(negedge clk_in);
      n++;
    end
    chk(name, EW'(busy_out), '0);
  endtask

  task automatic pulse_step();
    step_in = 1'b1;
    @(negedge clk_in);
    step_in = 1'b0;
  endtask

  typedef struct {
    logic [1:0] sw;
    logic [7:0] other;
    logic [7:0] d3;
    logic       with_run;
  } init_vec_t;
  init_vec_t tbl [4];

`ifdef LBM_BOUNCEBACK_EN
  logic [7:0] bb_exp [9] = '{8'd0, 8'd5, 8'd6, 8'd7, 8'd8, 8'd1, 8'd2, 8'd3, 8'd4};
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, w, s, d, r, n, prev_s;
    logic [WW-1:0] pat3, word;
    tbl[0] = '{2'b00, 8'd10, 8'd10, 1'b0};
    tbl[1] = '{2'b01, 8'd0, 8'd0, 1'b1};
    tbl[2] = '{2'b10, 8'd127, 8'd127, 1'b0};
    tbl[3] = '{2'b11, 8'd15, 8'd127, 1'b0};
    pat3 = mk_word(8'd15, 8'd127);
    step_in = 1'b0; run_in = 1'b0; init_in = 1'b0; sw_in = 2'b11;

    // reset state and initial SETUP with pattern 11
    repeat (3) @(negedge clk_in);
    chk("rst_wr_en", EW'(wr_en_out), '0);
    chk("rst_busy", EW'(busy_out), '0);
    chk("rst_count", EW'(step_count_out), '0);
    chk("rst_coll_valid", EW'(coll_valid_out), '0);
    chk("rst_stream_start", EW'(stream_start_out), '0);
    chk("rst_step_done", EW'(step_done_out), '0);
    chk("rst_state", EW'(dbg_state_out), '0);
    push_pass(pat3, N);
    rst_n_in = 1'b1;
    r = cyc;
    @(negedge clk_in);
    chk("setup_first_cycle", EW'(cyc), EW'(r + 1));
    chk("setup_first_wr", {EW'(wr_en_out), EW'(wr_addr_out)}, {EW'(1), EW'(0)});
    wait_idle("setup_idle");
    chk("setup_drained", EW'(exp_q.size()), '0);

    // table-driven re-initialisation through init_in
    for (int i = 0; i < 4; i++) begin
      push_pass(mk_word(tbl[i].other, tbl[i].d3), N);
      sw_in = tbl[i].sw;
      init_in = 1'b1;
      run_in = tbl[i].with_run;
      @(negedge clk_in);
      init_in = 1'b0;
      run_in = 1'b0;
      wait_idle("init_idle");
      chk("init_drained", EW'(exp_q.size()), '0);
    end

    // single step with an identity collider
    coll_add = 8'd0;
    push_pass(pat3, N);
    x = cyc;
    pulse_step();
    wait_for("step_first_wr", 0, 50, w);
    chk("step_wr_latency", EW'(w), EW'(x + 1 + RD_LAT + COLL_LAT));
    wait_for("step_stream_start", 1, 50, s);
    chk("step_pass_len", EW'(s), EW'(x + 1 + N + RD_LAT + COLL_LAT));
    repeat (3) @(negedge clk_in);
    chk("step_count_before_done", EW'(step_count_out), '0);
    chk("step_busy_in_stream", EW'(busy_out), EW'(1));
    man_done = 1'b1;
    @(negedge clk_in);
    man_done = 1'b0;
    chk("step_done_pulse", EW'(step_done_out), EW'(1));
    chk("step_count_1", EW'(step_count_out), EW'(1));
    chk("step_idle", EW'(busy_out), '0);
    @(negedge clk_in);
    chk("step_done_one_cycle", EW'(step_done_out), '0);
    chk("step_one_start", EW'(n_start), EW'(1));
    chk("step_drained", EW'(exp_q.size()), '0);
    man_done = 1'b1;
    @(negedge clk_in);
    man_done = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("done_ignored_in_wait", EW'(step_count_out), EW'(1));

    // free run for three steps with an incrementing collider
    coll_add = 8'd1;
    for (int i = 1; i <= 3; i++) push_pass(add_lanes(pat3, 8'(i)), N);
    auto_done = 1'b1;
    run_in = 1'b1;
    prev_s = 0;
    for (int i = 0; i < 3; i++) begin
      wait_for("run_stream_start", 1, 100, s);
      if (i == 2) run_in = 1'b0;
      if (i == 1) begin
        for (int t = 0; t < 4; t++) begin
          step_in = ~step_in;
          @(negedge clk_in);
        end
        step_in = 1'b0;
      end
      wait_for("run_step_done", 2, 100, d);
      chk("run_done_after_start", EW'(d), EW'(s + 6));
      if (i < 2) begin
        wait_for("run_next_wr", 0, 50, w);
        chk("run_back_to_back", EW'(w), EW'(d + 1 + RD_LAT + COLL_LAT));
        if (i == 0) begin
          for (int t = 0; t < 3; t++) begin
            step_in = 1'b1;
            @(negedge clk_in);
            step_in = 1'b0;
            @(negedge clk_in);
          end
        end
      end
      prev_s = s;
    end
    repeat (20) @(negedge clk_in);
    auto_done = 1'b0;
    chk("run_idle", EW'(busy_out), '0);
    chk("run_count_4", EW'(step_count_out), EW'(4));
    chk("run_done_pulses", EW'(n_done), EW'(4));
    chk("run_start_pulses", EW'(n_start), EW'(4));
    chk("run_drained", EW'(exp_q.size()), '0);

    // reset asserted mid-COLLIDE at write address 6
    coll_add = 8'd0;
    push_pass(add_lanes(pat3, 8'd3), 7);
    pulse_step();
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!(wr_en_out && wr_addr_out == 4'd6) && n < 50);
    chk("abort_reached_wr6", {EW'(wr_en_out), EW'(wr_addr_out)}, {EW'(1), EW'(6)});
    #1 rst_n_in = 1'b0;
    #1;
    chk("abort_wr_en", EW'(wr_en_out), '0);
    chk("abort_wr_data", EW'(wr_data_out), '0);
    chk("abort_busy", EW'(busy_out), '0);
    chk("abort_count", EW'(step_count_out), '0);
    chk("abort_rd_addr", EW'(rd_addr_out), '0);
    chk("abort_coll_valid", EW'(coll_valid_out), '0);
    chk("abort_drained", EW'(exp_q.size()), '0);
    sw_in = 2'b00;
    push_pass(mk_word(8'd10, 8'd10), N);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("abort_setup_restart", {EW'(wr_en_out), EW'(wr_addr_out)}, {EW'(1), EW'(0)});
    wait_idle("abort_setup_idle");
    chk("abort_setup_drained", EW'(exp_q.size()), '0);

`ifdef LBM_BOUNCEBACK_EN
    // bounce-back obstacle at (1,1): cell 5 is reversed, the rest take the collider output
    word = '0;
    for (int dd = 0; dd < 9; dd++) word[dd*8 +: 8] = 8'(dd);
    poke_addr = 4'd5;
    poke_data = word;
    poke_en = 1'b1;
    @(negedge clk_in);
    poke_en = 1'b0;
    coll_add = 8'd1;
    for (int k = 0; k < N; k++) begin
      if (k == 5) begin
        word = '0;
        for (int dd = 0; dd < 9; dd++) word[dd*8 +: 8] = bb_exp[dd];
      end else begin
        word = mk_word(8'd11, 8'd11);
      end
      exp_q.push_back({ADDR_W'(k), word});
    end
    auto_done = 1'b1;
    pulse_step();
    wait_for("bb_step_done", 2, 100, d);
    wait_idle("bb_idle");
    auto_done = 1'b0;
    chk("bb_count", EW'(step_count_out), EW'(1));
    chk("bb_drained", EW'(exp_q.size()), '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
